sram_like_slave: RTL
====================

Name: sram_like_slave

Overview:
- Responder end of the sram-like bus that cpu_core drives on its inst and data ports (req/wr/size/wstrb/addr/wdata in; addr_ok/data_ok/rdata out).
- Backed by a word-addressed internal memory.
- Accepts pipelined requests, queues them in order, and returns data_ok after a configurable delay.
- Used as the SoC-side inst/data memory model for single-core bring-up and as the bus functional responder in stage-level benches.

Parameters:
ADDR_WIDTH, 14, word-index width; memory holds 2^ADDR_WIDTH 32-bit words
MAX_OUTSTANDING, 4, response-queue depth (accepted but not yet answered requests); power of two, >=1
RESP_DELAY, 2, cycles from address handshake to earliest data_ok for that request; >=1

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous active-high reset
req  in  1  request valid
wr  in  1  1 = write, 0 = read
size  in  2  0 byte, 1 half, 2 word; recorded, not used for access (byte lanes come from wstrb)
wstrb  in  4  byte-lane write enables, writes only
addr  in  32  byte address; word index = addr[ADDR_WIDTH+1:2], other bits ignored
wdata  in  32  write data, lanes aligned to addr[1:0] by master
addr_ok  out  1  request accepted this cycle when req && addr_ok
data_ok  out  1  one-cycle response strobe for head of queue
rdata  out  32  read data, valid with data_ok

Behaviour:
- Reset (sync, active-high): queue count 0, read/write pointers 0, all entry timers 0, data_ok 0, rdata 0, addr_ok 1 from first cycle after reset. Memory contents are not reset.
- Handshake: accept = req && addr_ok. addr_ok = (count != MAX_OUTSTANDING), from registered count only; no same-cycle pop bypass. Master holds req/addr/etc. while addr_ok is low; slave takes no action on a non-accepted req.
- Memory access at acceptance:
  - Write: each lane i with wstrb[i]=1 updates mem[idx][8i+7:8i] on that clock edge.
  - Read: samples mem[idx] on that edge, after any write earlier in program order. A read accepted the cycle after a write to the same word returns the new data.
  - Entry pushed: {is_write, data = read word or 0, timer = RESP_DELAY-1}.
- Timers: every cycle each valid entry's timer decrements, saturating at 0.
- Response: data_ok = (count != 0) && head.timer == 0. Combinational from registered state, so it lands exactly RESP_DELAY cycles after acceptance when the entry is at the head, later if queued behind others.
- Response ordering and rate: strictly in order, at most one data_ok per cycle. No backpressure on data_ok; master must consume it. On data_ok the head pops.
- rdata = head.data when data_ok, else 0. Writes also answer data_ok with rdata = 0.
- Count update: push only +1, pop only -1, push and pop in the same cycle leaves count unchanged (legal only when count < MAX). Pointers wrap modulo MAX_OUTSTANDING.
- Full: count == MAX → addr_ok = 0 until the cycle after a pop.
- Empty: data_ok = 0, rdata = 0.
- Reset mid-flight: all queued responses are dropped and no data_ok is issued for them. Writes already accepted remain in memory.
- Out-of-range upper address bits alias into memory; no error response.

Test Plan:
1. Reset for 3 cycles, req=0 → addr_ok=1, data_ok=0, rdata=0 in every cycle after reset.
2. RESP_DELAY=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF accepted at cycle T; read addr 0x10 accepted at T+1 → data_ok at T+2 (rdata 0) and T+3 (rdata 0xDEADBEEF).
3. Byte write to addr 0x11, wdata 0x0000AB00, wstrb 4'b0010; then word read of 0x10 → rdata 0xDEADABEF. Halfword write wstrb 4'b1100, wdata 0x12340000 to 0x12, then read → 0x1234ABEF.
4. RESP_DELAY=8, MAX_OUTSTANDING=4: reads accepted at T..T+3 with req held high:
   - addr_ok low T+4..T+8.
   - data_ok at T+8, T+9, T+10, T+11 in request order.
   - Fifth request accepted at T+9 and answered at T+17.
5. count=3 with head timer 0 and a new req in the same cycle → accept and pop together, count stays 3, addr_ok stays 1, next data_ok is the next-oldest entry.
6. Two reads pending (RESP_DELAY=4), reset asserted one cycle before the first response → no data_ok for 10 cycles after reset. A write accepted before the reset remains visible to a read issued after reset.

Source files
------------

// File: rtl/sram_like_slave.sv
// Responder for the sram-like bus: word-addressed memory behind an in-order
// response queue that answers each accepted request RESP_DELAY cycles later.
module sram_like_slave #(
    parameter int ADDR_WIDTH      = 14,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DELAY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(RESP_DELAY + 1);
    localparam logic [CW-1:0] FULL   = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] T_INIT = TW'(RESP_DELAY - 1);

    logic [31:0]   r_mem   [2**ADDR_WIDTH];
    logic [31:0]   r_data  [MAX_OUTSTANDING];
    logic [TW-1:0] r_timer [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    // size and the non-index address bits carry no meaning for this model
    assign w_unused = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign w_idx   = addr[ADDR_WIDTH+1:2];
    assign addr_ok = (r_count != FULL);
    assign w_push  = req && addr_ok && !reset;
    assign data_ok = (r_count != '0) && (r_timer[r_rptr] == '0);
    assign w_pop   = data_ok;
    assign rdata   = data_ok ? r_data[r_rptr] : '0;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push && wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_timer[i] <= '0;
        end else begin
            // Free slots saturate at 0 harmlessly; a push reloads its slot below.
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (r_timer[i] != '0) r_timer[i] <= r_timer[i] - TW'(1);
            end
            if (w_push) begin
                r_data[r_wptr]  <= wr ? '0 : r_mem[w_idx];
                r_timer[r_wptr] <= T_INIT;
                r_wptr          <= f_next(r_wptr);
            end
            if (w_pop) r_rptr <= f_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
